ha_resp_checker: RTL

HA_RESP_CHECKER -- requirements
Module: ha_resp_checker

---
 rtl/ha_chk_pkg.sv | 14 +
 rtl/ha_golden.sv | 13 +
 rtl/ha_resp_checker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ha_chk_pkg.sv
// Shared types for the half-adder response checker: FSM states and the {c,s} result pair.
package ha_chk_pkg;

  localparam int RES_W = 2;

  typedef logic [RES_W-1:0] res_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ha_golden.sv
// Golden half-adder: {c_exp,s_exp} from a and b, purely combinational (latency 0).
// No flow control; the result follows the operands in the same cycle.
module ha_golden
  import ha_chk_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] res
);

  assign res = {a & b, a ^ b};

endmodule

// File: rtl/ha_resp_checker.sv
// Checks NUM_VEC half-adder responses per run and counts pass/fail; results register 1 cycle after a transfer.
// in_ready/in_valid handshake: ready only in CHECK while vectors remain; offers without ready are dropped.
module ha_resp_checker
  import ha_chk_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             s,
  input  logic             c,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [RES_W-1:0] first_fail_exp,
  output logic [RES_W-1:0] first_fail_got,
  output logic             done
);

  // The index must be able to reach NUM_VEC even when the counters are narrower.
  localparam int IDX_NEED = $clog2(NUM_VEC + 1);
  localparam int IDX_W    = (IDX_NEED > CNT_W) ? IDX_NEED : CNT_W;
  localparam logic [IDX_W-1:0] NUM_VEC_V  = IDX_W'(NUM_VEC);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  res_t             golden;
  res_t             got;
  logic             take;
  logic             hit;
  logic             clr;

  ha_golden u_golden (
    .a   (a),
    .b   (b),
    .res (golden)
  );

  assign got  = {c, s};
  assign hit  = (got == golden);
  assign take = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        in_ready = (idx < NUM_VEC_V);
        // Final transfer: counts and done become visible on the same edge.
        if (take && (idx == LAST_IDX)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          clr       = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      mismatch       <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      mismatch <= 1'b0;
      if (clr) begin
        idx            <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_idx <= '0;
        first_fail_exp <= '0;
        first_fail_got <= '0;
      end else if (take) begin
        idx <= idx + 1'b1;
        if (hit) begin
          if (pass_cnt != CNT_MAX) begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end else begin
          mismatch <= 1'b1;
          if (fail_cnt != CNT_MAX) begin
            fail_cnt <= fail_cnt + 1'b1;
          end
          // fail_cnt saturates but never returns to zero, so zero means "no failure yet".
          if (fail_cnt == '0) begin
            first_fail_idx <= CNT_W'(idx);
            first_fail_exp <= golden;
            first_fail_got <= got;
          end
        end
      end
    end
  end

endmodule
